biriscv_fetch_align: RTL

//  Fetch stage directly upstream of the decode FIFO. Issues 64-bit-aligned
//  I-cache reads, tracks one outstanding request and drops stale responses

---
 rtl/biriscv_fetch_align.sv | 131 +++++++++++++
 1 files changed

// File: rtl/biriscv_fetch_align.sv
// Fetch stage feeding the decode FIFO: aligned I-cache reads, one outstanding request,
// stale-response drop after redirect, 1-entry skid. Define BIRISCV_FETCH_BPU_EN to follow BPU predictions.
module biriscv_fetch_align #(
  parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [1:0]  branch_priv_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  input  logic [63:0] icache_inst_i,
  input  logic        fetch_accept_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic [31:0] pc_f_o,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o
);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        fault_fetch;
    logic        fault_page;
  } pkt_t;

  logic        active_q, outstanding_q, drop_q, skid_q, fault_stall_q;
  logic [31:0] pc_f_q, pc_q;
  logic [1:0]  priv_q, pred_q;
  pkt_t        skid_pkt_q, live_pkt, out_pkt;
  logic [31:0] pc_next, pc_seq;
  logic [1:0]  pred_f;
  logic        rd, req, live_valid, fault_any, valid;

  assign pc_seq = {pc_f_q[31:3] + 29'd1, 3'b000};

`ifdef BIRISCV_FETCH_BPU_EN
  assign pred_f  = next_taken_f_i;
  assign pc_next = (next_taken_f_i != 2'b00) ? next_pc_f_i : pc_seq;
`else
  logic unused_bpu;
  assign unused_bpu = ^{next_pc_f_i, next_taken_f_i};
  assign pred_f  = 2'b00;
  assign pc_next = pc_seq;
`endif

  // A new read may overlap the response only if that response is consumed or discarded now
  assign rd  = active_q & ~branch_request_i & ~fault_stall_q & ~skid_q &
               (~outstanding_q | (icache_valid_i & (fetch_accept_i | drop_q)));
  assign req = rd & icache_accept_i;

  assign live_valid = icache_valid_i & ~drop_q;
  assign live_pkt   = '{instr: icache_inst_i, pc: pc_q, pred: pred_q,
                        fault_fetch: icache_error_i, fault_page: icache_page_fault_i};
  assign out_pkt    = skid_q ? skid_pkt_q : live_pkt;
  assign fault_any  = out_pkt.fault_fetch | out_pkt.fault_page;
  assign valid      = (skid_q | live_valid) & ~branch_request_i;

  assign icache_rd_o         = rd;
  assign icache_pc_o         = {pc_f_q[31:3], 3'b000};
  assign icache_priv_o       = priv_q;
  assign pc_f_o              = pc_f_q;
  assign fetch_valid_o       = valid;
  assign fetch_pc_o          = out_pkt.pc;
  assign fetch_pred_branch_o = out_pkt.pred;
  assign fetch_fault_fetch_o = out_pkt.fault_fetch;
  assign fetch_fault_page_o  = out_pkt.fault_page;
  // Entering mid-line: slot0 precedes the target, so it becomes a NOP
  assign fetch_instr_o = fault_any    ? 64'd0 :
                         out_pkt.pc[2] ? {out_pkt.instr[63:32], NOP} : out_pkt.instr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q      <= 1'b0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skid_q        <= 1'b0;
      fault_stall_q <= 1'b0;
      pc_f_q        <= BOOT_VECTOR;
      pc_q          <= 32'd0;
      priv_q        <= 2'b11;
      pred_q        <= 2'b00;
      skid_pkt_q    <= '0;
    end else begin
      active_q <= 1'b1;
      if (branch_request_i) begin
        pc_f_q        <= branch_pc_i;
        priv_q        <= branch_priv_i;
        skid_q        <= 1'b0;
        fault_stall_q <= 1'b0;
        // Remember to discard the response still in flight
        drop_q        <= outstanding_q & ~icache_valid_i;
        if (icache_valid_i)
          outstanding_q <= 1'b0;
      end else begin
        if (req) begin
          outstanding_q <= 1'b1;
          pc_q          <= pc_f_q;
          pred_q        <= pred_f;
          pc_f_q        <= pc_next;
        end else if (icache_valid_i) begin
          outstanding_q <= 1'b0;
        end
        if (icache_valid_i)
          drop_q <= 1'b0;
        if (skid_q) begin
          if (fetch_accept_i)
            skid_q <= 1'b0;
        end else if (live_valid & ~fetch_accept_i) begin
          skid_q     <= 1'b1;
          skid_pkt_q <= live_pkt;
        end
        if (valid & fetch_accept_i & fault_any)
          fault_stall_q <= 1'b1;
      end
    end
  end
endmodule
